uart_rx_fifo: RTL

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each single-cycle rx_valid/rx_data pulse from the receiver, which has no backpressure, into a circular FIFO. It presents the bytes to the consumer (CPU bus or packet parser) over a ready/valid stream. It reports fill level, an almost-full warning and a sticky overrun flag for bytes lost when the buffer is full.

---
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 51 +++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver strobe, consumer stream and status signals of the rx byte buffer
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_valid;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     flush;
  logic                     overrun_clr;
  logic [$clog2(DEPTH):0]   count;
  logic                     almost_full;
  logic                     overrun;
  modport master (
    output rx_data, rx_valid, out_ready, flush, overrun_clr,
    input  out_data, out_valid, count, almost_full, overrun
  );
  modport slave (
    input  rx_data, rx_valid, out_ready, flush, overrun_clr,
    output out_data, out_valid, count, almost_full, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT circular byte buffer behind a UART receiver with sticky overrun
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input logic clock,
  input logic reset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic ovr, full, pop, push, drop;
  always_comb begin
    full            = cnt == CW'(DEPTH);
    pop             = (cnt != '0) && bus.out_ready;
    push            = bus.rx_valid && (!full || pop);
    drop            = bus.rx_valid && full && !pop && !bus.flush;
    bus.out_data    = mem[rd_ptr];
    bus.out_valid   = cnt != '0;
    bus.count       = cnt;
    bus.almost_full = cnt >= CW'(AFULL_LEVEL);
    bus.overrun     = ovr;
  end
  // flush outranks push/pop; overrun set outranks its clear
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= bus.rx_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
      ovr <= drop || (ovr && !bus.overrun_clr);
    end
endmodule
